// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
//   fetch_state_e        : fetch controller states
//   PC_INC               : PC increment per fetched instruction (bytes)
//   DEFAULT_RESET_VECTOR : PC loaded on reset unless overridden
//   IF_ADDR_W/IF_DATA_W  : default address / instruction widths
package if_pkg;

    localparam int unsigned IF_ADDR_W = 32;
    localparam int unsigned IF_DATA_W = 32;
    localparam int unsigned PC_INC    = 4;

    localparam logic [IF_ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

    // S_FETCH: requesting/accepting; S_FULL: output and skid both occupied;
    // S_FLUSH: waiting out a fetch that a redirect made stale.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

endpackage : if_pkg

// File: rtl/if_fetch_skid.sv
// One-entry skid buffer holding a fetched {instr, pc} pair while ID stalls.
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset
//   load_i             : capture instr_i/pc_i, mark full
//   unload_i           : entry consumed, mark empty
//   clear_i            : drop the entry (redirect), wins over load/unload
//   instr_i, pc_i      : entry to capture
//   full_o             : entry valid
//   instr_o, pc_o      : held entry
module if_fetch_skid
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W = IF_ADDR_W,
    parameter int unsigned DATA_W = IF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              full_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              full_q,  full_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;

    // Next-entry selection: clear > load > unload.
    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            full_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule : if_fetch_skid

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller for the IF stage: owns the PC, drives the
// instruction-memory request handshake, and presents fetched instructions
// (with PC and PC+4) to ID, absorbing one cycle of ID back-pressure in a skid
// buffer and discarding in-flight fetches on branch/jump redirects.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   o_imem_req/o_imem_addr: fetch request and word-aligned address
//   i_imem_ack/i_imem_rdata: request accepted, instruction returned same cycle
//   i_id_stall            : ID holds the output register
//   i_redirect/_addr      : one-cycle taken branch/jump and its target
//   o_valid/o_instr/o_pc/o_pcadd4 : instruction presented to ID
//   o_addr_exc            : only with IF_ADDR_EXC_EN; misaligned redirect seen
// Build option: define IF_ADDR_EXC_EN to flag misaligned redirect targets and
// halt fetching until the next redirect; otherwise targets are silently aligned.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W       = IF_ADDR_W,
    parameter int unsigned       DATA_W       = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    input  logic              i_id_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc,
`ifdef IF_ADDR_EXC_EN
    output logic [ADDR_W-1:0] o_pcadd4,
    output logic              o_addr_exc
`else
    output logic [ADDR_W-1:0] o_pcadd4
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              req_q,   req_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] opc_q,   opc_d;
    logic [ADDR_W-1:0] opc4_q,  opc4_d;
`ifdef IF_ADDR_EXC_EN
    logic              exc_q,   exc_d;
`endif

    logic              ack_c;
    logic              consume_c;
    logic              skid_load, skid_unload, skid_clear;
    logic              skid_full;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    // An ack only counts against a request actually on the bus.
    assign ack_c     = req_q && i_imem_ack;
    assign consume_c = valid_q && !i_id_stall;

    if_fetch_skid #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .instr_i  (i_imem_rdata),
        .pc_i     (pc_q),
        .full_o   (skid_full),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    // Next-state, PC and output-register update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        opc_d       = opc_q;
        opc4_d      = opc4_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
`ifdef IF_ADDR_EXC_EN
        exc_d       = exc_q;
`endif

        if (i_redirect) begin
            // Redirect beats stall and ack; a same-cycle ack is dropped.
            pc_d       = i_redirect_addr & ALIGN_MASK;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            state_d    = (req_q && !i_imem_ack) ? S_FLUSH : S_FETCH;
`ifdef IF_ADDR_EXC_EN
            exc_d = (i_redirect_addr[1:0] != 2'b00);
            if (exc_d) begin
                state_d = S_FETCH;
            end
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ack_c) begin
                        pc_d = pc_q + PC_STEP;
                        if (!valid_q || !i_id_stall) begin
                            valid_d = 1'b1;
                            instr_d = i_imem_rdata;
                            opc_d   = pc_q;
                            opc4_d  = pc_q + PC_STEP;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_FULL;
                        end
                    end else if (consume_c) begin
                        valid_d = 1'b0;
                    end
                end
                S_FULL: begin
                    if (consume_c) begin
                        instr_d     = skid_instr;
                        opc_d       = skid_pc;
                        opc4_d      = skid_pc + PC_STEP;
                        skid_unload = 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                S_FLUSH: begin
                    // Stale data is discarded; pc already holds the target.
                    if (ack_c) begin
                        state_d = S_FETCH;
                    end
                    if (consume_c) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

        // A flushing request keeps its stale address until acked.
        addr_d = (state_d == S_FLUSH) ? addr_q : pc_d;
`ifdef IF_ADDR_EXC_EN
        req_d  = (state_d != S_FULL) && !exc_d;
`else
        req_d  = (state_d != S_FULL);
`endif
    end

    // State and output registers; req stays low through reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            opc4_q  <= PC_STEP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            opc4_q  <= opc4_d;
        end
    end

`ifdef IF_ADDR_EXC_EN
    // Misaligned-redirect flag, cleared only by the next redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign o_addr_exc = exc_q;
`endif

    assign o_imem_req  = req_q;
    assign o_imem_addr = addr_q;
    assign o_valid     = valid_q;
    assign o_instr     = instr_q;
    assign o_pc        = opc_q;
    assign o_pcadd4    = opc4_q;

endmodule : if_fetch_ctrl

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the ARC MIPS IF stage.
- Owns the architectural PC register and drives the request side of the instruction-memory handshake.
- Delivers fetched instructions, with their PC and PC+4, to the IF/ID boundary.
- Handles ID back-pressure through a one-entry skid buffer, and branch/jump redirects by discarding any in-flight fetch.

Parameters:
RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
ADDR_W, 32, PC and memory address width.
DATA_W, 32, instruction width.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  reset, asynchronous assert, active-low.
o_imem_req  out  1  fetch request valid.
o_imem_addr  out  ADDR_W  fetch address, word aligned.
i_imem_ack  in  1  request accepted and data returned this cycle.
i_imem_rdata  in  DATA_W  instruction; valid only when i_imem_ack=1.
i_id_stall  in  1  ID cannot accept; holds the output register.
i_redirect  in  1  branch/jump taken; one-cycle pulse.
i_redirect_addr  in  ADDR_W  redirect target.
o_valid  out  1  o_instr/o_pc hold a valid instruction.
o_instr  out  DATA_W  fetched instruction.
o_pc  out  ADDR_W  PC of o_instr.
o_pcadd4  out  ADDR_W  o_pc + 4, used for link.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous and active-low.
- Reset values: pc=RESET_VECTOR, state=S_FETCH, o_valid=0, o_instr=0, o_pc=0, skid empty. o_imem_req=0 while i_rst_n=0.
- Address: o_imem_addr=pc; bits[1:0] are always 0.
- Request rule: o_imem_req=1 in S_FETCH and S_FLUSH. Once asserted, req and addr stay stable until i_imem_ack. Ack in the first req cycle is legal, giving zero wait states.
- Accept (ack in S_FETCH, no redirect):
  - pc<=pc+4, wrapping modulo 2^ADDR_W.
  - If the output is empty or consumed this cycle (o_valid=0 or i_id_stall=0), data, pc and pc+4 load the output and o_valid<=1 next cycle.
  - Otherwise data loads the skid and the state goes to S_FULL.
- Consume: the output is consumed when o_valid=1 and i_id_stall=0. With nothing new arriving, o_valid<=0.
- S_FULL: o_imem_req=0. On consume, skid→output and state→S_FETCH. The next request is issued the following cycle.
- Redirect (highest priority, beats stall and ack):
  - pc<=i_redirect_addr with bits[1:0] forced to 00.
  - o_valid<=0 and skid cleared.
  - If a request is outstanding and not acked this cycle, state→S_FLUSH; otherwise state→S_FETCH.
  - An ack in the same cycle is dropped.
- S_FLUSH: req stays at the stale address until ack. The acked data is discarded and pc is not incremented; state→S_FETCH. A further redirect in S_FLUSH updates pc and remains in S_FLUSH.
- Throughput and latency: at most one outstanding request, one instruction per cycle sustained with zero-wait memory. An instruction appears at the output one cycle after its ack.
- Reset mid-operation: immediate return to reset values; an outstanding memory transaction is abandoned.

Optional Feature:
IF_ADDR_EXC_EN
- Defined: adds output o_addr_exc (1 bit, reset 0).
  - A redirect with i_redirect_addr[1:0]!=0 sets o_addr_exc on the next cycle, loads pc with the aligned address and blocks requests (state S_FULL-like hold).
  - o_addr_exc clears only on the next redirect or reset.
- Undefined: no port; misaligned targets are silently aligned.

Decomposition:
- Package if_pkg: fetch_state_e enum (S_FETCH, S_FULL, S_FLUSH), PC_INC=4, RESET_VECTOR default.
- Sub-module if_fetch_skid: one-entry buffer holding {instr, pc}, with load/unload/clear.
- o_pcadd4 comes from the existing IF_pcadd adder.

Test Plan:
1. Reset release, ack every cycle, no stall -> addrs BFC00000, BFC00004, BFC00008; o_valid from cycle 2; o_pcadd4=o_pc+4.
2. Ack held low 3 cycles -> req/addr stable at BFC00000 for all 3 cycles; one instruction out after ack, pc→BFC00004.
3. i_id_stall=1 for 4 cycles with acks available -> one fetch goes to the output and one to the skid, then req=0. After stall drops: outputs BFC00000, BFC00004, BFC00008 in order, no loss or duplicate.
4. Redirect to 00400020 while req outstanding at BFC00008 (ack 2 cycles later) -> stale data dropped, o_valid=0, next req addr 00400020.
5. Redirect coincident with ack and stall -> ack data dropped, skid cleared, next req at target the following cycle.
6. Redirect to 00400022: with IF_ADDR_EXC_EN, o_addr_exc=1 and no req; without it, req addr=00400020.
